ps2_line_assembler: RTL and testbench

Parametrised successor to the fixed 256-bit PS2 line processor. It collects cleaned ASCII characters from the PS2 cleaner into a double-buffered line. It supports backspace, configurable line length and character width, and overflow/drop reporting. A committed line is held under a ready/ack handshake for the display controller or processor, while the user keeps typing into the edit buffer.

---
 rtl/ps2_line_assembler.sv | 136 +++++++++++++
 tb/tb_ps2_line_assembler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_line_assembler.sv
// rtl/ps2_line_assembler.sv - double-buffered PS2 line assembler with backspace and overflow/drop reporting
module ps2_line_assembler #(
    parameter int                MAX_CHARS  = 32,
    parameter int                CHAR_W     = 8,
    parameter int                LINE_W     = MAX_CHARS * CHAR_W,
    parameter int                LEN_W      = $clog2(MAX_CHARS + 1),
    parameter logic [CHAR_W-1:0] ENTER_CODE = 8'h0D,
    parameter logic [CHAR_W-1:0] BKSP_CODE  = 8'h08
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [CHAR_W-1:0] input_character,
    input  logic              input_made,
    input  logic              line_ack,
    output logic [LINE_W-1:0] line_content,
    output logic [LEN_W-1:0]  line_length,
    output logic              line_ready,
    output logic [LINE_W-1:0] edit_content,
    output logic [LEN_W-1:0]  edit_length,
    output logic              overflow,
    output logic [7:0]        dropped_count
);

    typedef enum logic {
        EDIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                made_q;
    logic [LINE_W-1:0]   edit_buf_q, edit_buf_d;
    logic [LEN_W-1:0]    edit_len_q, edit_len_d;
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;
    logic [LEN_W-1:0]    line_len_q, line_len_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          dropped_q, dropped_d;

    logic                strobe;
    logic                is_enter;
    logic                is_bksp;
    logic                commit;

    // State, buffers and the input_made edge detector; reset discards any unacked line
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= EDIT;
            made_q     <= 1'b0;
            edit_buf_q <= '0;
            edit_len_q <= '0;
            line_buf_q <= '0;
            line_len_q <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            made_q     <= input_made;
            edit_buf_q <= edit_buf_d;
            edit_len_q <= edit_len_d;
            line_buf_q <= line_buf_d;
            line_len_q <= line_len_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Decode one character per rising strobe edge and work out the next buffer/FSM state
    always_comb begin
        state_d    = state_q;
        edit_buf_d = edit_buf_q;
        edit_len_d = edit_len_q;
        line_buf_d = line_buf_q;
        line_len_d = line_len_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        commit     = 1'b0;

        strobe   = input_made && !made_q;
        is_enter = (input_character == ENTER_CODE);
        is_bksp  = (input_character == BKSP_CODE);

        if (strobe) begin
            if (is_enter) begin
                // Empty lines are never committed nor counted as drops
                if (edit_len_q != '0) begin
                    // An ack arriving with the Enter frees the committed slot in time
                    if (state_q == EDIT || line_ack) begin
                        commit = 1'b1;
                    end else if (dropped_q != 8'hFF) begin
                        dropped_d = dropped_q + 8'd1;
                    end
                end
            end else if (is_bksp) begin
                if (edit_len_q != '0) begin
                    edit_len_d = edit_len_q - LEN_W'(1);
                    for (int i = 0; i < MAX_CHARS; i++) begin
                        if (LEN_W'(i) == edit_len_q - LEN_W'(1)) begin
                            edit_buf_d[i*CHAR_W +: CHAR_W] = '0;
                        end
                    end
                end
            end else begin
                if (edit_len_q == LEN_W'(MAX_CHARS)) begin
                    overflow_d = 1'b1;
                end else begin
                    edit_len_d = edit_len_q + LEN_W'(1);
                    for (int i = 0; i < MAX_CHARS; i++) begin
                        if (LEN_W'(i) == edit_len_q) begin
                            edit_buf_d[i*CHAR_W +: CHAR_W] = input_character;
                        end
                    end
                end
            end
        end

        if (commit) begin
            line_buf_d = edit_buf_q;
            line_len_d = edit_len_q;
            edit_buf_d = '0;
            edit_len_d = '0;
            overflow_d = 1'b0;
            state_d    = READY;
        end else if (state_q == READY && line_ack) begin
            // Committed line stays visible after the ack; only the ready flag drops
            state_d = EDIT;
        end
    end

    assign line_content  = line_buf_q;
    assign line_length   = line_len_q;
    assign line_ready    = (state_q == READY);
    assign edit_content  = edit_buf_q;
    assign edit_length   = edit_len_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_ps2_line_assembler.sv
// tb/tb_ps2_line_assembler.sv - randomized self-checking bench for ps2_line_assembler against a queue model
module tb_ps2_line_assembler;

    localparam int MAXC = 32;
    localparam logic [7:0] ENT = 8'h0D;
    localparam logic [7:0] BKS = 8'h08;

    logic         clock = 1'b0;
    logic         resetn;
    logic [7:0]   input_character;
    logic         input_made;
    logic         line_ack;
    logic [255:0] line_content;
    logic [5:0]   line_length;
    logic         line_ready;
    logic [255:0] edit_content;
    logic [5:0]   edit_length;
    logic         overflow;
    logic [7:0]   dropped_count;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    logic [7:0] m_edit[$];
    logic [7:0] m_line[$];
    bit         m_ready;
    bit         m_ovf;
    int         m_drops;
    bit         m_prev_made;

    ps2_line_assembler dut (
        .clock          (clock),
        .resetn         (resetn),
        .input_character(input_character),
        .input_made     (input_made),
        .line_ack       (line_ack),
        .line_content   (line_content),
        .line_length    (line_length),
        .line_ready     (line_ready),
        .edit_content   (edit_content),
        .edit_length    (edit_length),
        .overflow       (overflow),
        .dropped_count  (dropped_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_edit();
        logic [255:0] v = '0;
        foreach (m_edit[i]) v[i*8 +: 8] = m_edit[i];
        return v;
    endfunction

    function automatic logic [255:0] pack_line();
        logic [255:0] v = '0;
        foreach (m_line[i]) v[i*8 +: 8] = m_line[i];
        return v;
    endfunction

    task automatic model_update(input bit m, input logic [7:0] c, input bit a, input bit r);
        bit was_ready;
        bit committed;
        if (!r) begin
            m_edit.delete();
            m_line.delete();
            m_ready = 0; m_ovf = 0; m_drops = 0; m_prev_made = 0;
            return;
        end
        was_ready = m_ready;
        committed = 0;
        if (m && !m_prev_made) begin
            if (c == ENT) begin
                if (m_edit.size() > 0) begin
                    if (!was_ready || a) begin
                        m_line = m_edit;
                        m_edit.delete();
                        m_ovf = 0;
                        m_ready = 1;
                        committed = 1;
                    end else if (m_drops < 255) begin
                        m_drops++;
                    end
                end
            end else if (c == BKS) begin
                if (m_edit.size() > 0) void'(m_edit.pop_back());
            end else begin
                if (m_edit.size() < MAXC) m_edit.push_back(c);
                else m_ovf = 1;
            end
        end
        m_prev_made = m;
        if (was_ready && a && !committed) m_ready = 0;
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".line_content"}, line_content, pack_line());
        check({ph, ".line_length"}, 256'(line_length), 256'(m_line.size()));
        check({ph, ".line_ready"}, 256'(line_ready), 256'(m_ready));
        check({ph, ".edit_content"}, edit_content, pack_edit());
        check({ph, ".edit_length"}, 256'(edit_length), 256'(m_edit.size()));
        check({ph, ".overflow"}, 256'(overflow), 256'(m_ovf));
        check({ph, ".dropped"}, 256'(dropped_count), 256'(m_drops));
    endtask

    task automatic step(input string ph, input bit m, input logic [7:0] c, input bit a, input bit r);
        input_made = m; input_character = c; line_ack = a; resetn = r;
        @(posedge clock); #1;
        model_update(m, c, a, r);
        compare_all(ph);
    endtask

    task automatic type_char(input string ph, input logic [7:0] c);
        step(ph, 1'b1, c, 1'b0, 1'b1);
        step(ph, 1'b0, c, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] c;
        bit m, a, r;
        input_made = 0; input_character = 0; line_ack = 0; resetn = 0;
        m_ready = 0; m_ovf = 0; m_drops = 0; m_prev_made = 0;
        #1;
        step("rst", 0, 8'h00, 0, 0);
        step("rst", 0, 8'h00, 0, 0);
        check("rst_ready_const", 256'(line_ready), 256'(0));
        check("rst_edit_len_const", 256'(edit_length), 256'(0));
        check("rst_line_const", line_content, 256'(0));

        // ABC + Enter
        type_char("abc", 8'h41);
        check("abc_len1", 256'(edit_length), 256'(1));
        type_char("abc", 8'h42);
        type_char("abc", 8'h43);
        check("abc_len3", 256'(edit_length), 256'(3));
        step("abc", 1, ENT, 0, 1);
        check("abc_ready", 256'(line_ready), 256'(1));
        check("abc_content", line_content, 256'(24'h434241));
        check("abc_length", 256'(line_length), 256'(3));
        check("abc_edit_len", 256'(edit_length), 256'(0));
        step("abc", 0, ENT, 1, 1);
        check("abc_acked", 256'(line_ready), 256'(0));

        // XY then backspaces past empty, Enter on empty line
        type_char("bks", 8'h58);
        type_char("bks", 8'h59);
        type_char("bks", BKS);
        type_char("bks", BKS);
        type_char("bks", BKS);
        type_char("bks", ENT);
        check("bks_not_ready", 256'(line_ready), 256'(0));
        check("bks_drops", 256'(dropped_count), 256'(0));

        // 33 chars: overflow, Enter commits 32 and clears overflow
        for (int i = 0; i < 33; i++) type_char("ovf", 8'(8'h21 + i));
        check("ovf_len", 256'(edit_length), 256'(32));
        check("ovf_flag", 256'(overflow), 256'(1));
        type_char("ovf", ENT);
        check("ovf_cleared", 256'(overflow), 256'(0));
        check("ovf_line_len", 256'(line_length), 256'(32));
        step("ovf", 0, 0, 1, 1);

        // HI committed, Z typed, Enter dropped, then ack+Enter commits Z
        type_char("hi", 8'h48);
        type_char("hi", 8'h49);
        type_char("hi", ENT);
        type_char("hi", 8'h5A);
        type_char("hi", ENT);
        check("hi_line", line_content, 256'(16'h4948));
        check("hi_drop", 256'(dropped_count), 256'(1));
        step("hi", 1, ENT, 1, 1);
        check("hi_ackenter_line", line_content, 256'(8'h5A));
        check("hi_ackenter_ready", 256'(line_ready), 256'(1));
        step("hi", 0, ENT, 1, 1);

        // held strobe takes one char
        for (int i = 0; i < 5; i++) step("hold", 1, 8'h51, 0, 1);
        step("hold", 0, 8'h51, 0, 1);
        check("hold_len", 256'(edit_length), 256'(1));

        // dropped_count saturation
        type_char("sat", ENT);
        type_char("sat", 8'h61);
        for (int i = 0; i < 260; i++) type_char("sat", ENT);
        check("sat_drop", 256'(dropped_count), 256'(255));

        // reset while ready with a partial edit
        type_char("mid", 8'h62);
        step("mid", 0, 0, 0, 0);
        check("mid_ready", 256'(line_ready), 256'(0));
        check("mid_drop", 256'(dropped_count), 256'(0));
        type_char("mid", 8'h63);
        type_char("mid", ENT);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    c = ENT;
                2:       c = BKS;
                default: c = 8'(8'h20 + $urandom_range(0, 94));
            endcase
            m = ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 499) != 0);
            step("rnd", m, c, a, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
